// File: rtl/drink_pkg.sv
// rtl/drink_pkg.sv - shared types, op encodings and default prices for the drink vending controller
package drink_pkg;

   typedef logic [3:0] coin_t;

   localparam logic [1:0] OP_AGUA    = 2'b00;
   localparam logic [1:0] OP_FANTA   = 2'b01;
   localparam logic [1:0] OP_GUARANA = 2'b10;
   localparam logic [1:0] OP_INVALID = 2'b11;

   localparam coin_t DEF_PRICE_AGUA    = 4'd4;
   localparam coin_t DEF_PRICE_FANTA   = 4'd6;
   localparam coin_t DEF_PRICE_GUARANA = 4'd5;
   localparam coin_t COIN_MAX          = 4'd15;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      REFUND   = 2'd2
   } state_t;

endpackage

// File: rtl/drink_rise_detect.sv
// rtl/drink_rise_detect.sv - rising-edge detector: one history register and an AND
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic ev_o
);

   logic d_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) d_q <= 1'b0;
      else     d_q <= d_i;
   end

   assign ev_o = d_i & ~d_q;

endmodule

// File: rtl/drink.sv
// rtl/drink.sv - coin-operated drink vending controller (top)
// Optional: DRINK_OVERFLOW_REFUND_EN refunds a coin inserted at full balance.
module drink
   import drink_pkg::*;
#(
   parameter coin_t PRICE_AGUA    = DEF_PRICE_AGUA,
   parameter coin_t PRICE_FANTA   = DEF_PRICE_FANTA,
   parameter coin_t PRICE_GUARANA = DEF_PRICE_GUARANA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       confirma,
   input  logic       moeda,
   input  logic [1:0] op,
   output logic       entrega_agua,
   output logic       entrega_fanta,
   output logic       entrega_guarana,
   output logic       sinal_devolve,
   output logic [3:0] troco,
   output logic [3:0] saldo
);

   logic   coin_ev, conf_ev;
   state_t state_q, state_d;
   coin_t  saldo_q, saldo_d, troco_q, troco_d;
   logic   agua_q, agua_d, fanta_q, fanta_d, guarana_q, guarana_d, devolve_q, devolve_d;
   coin_t  price;
   logic   op_valid;
   coin_t  saldo_inc;

   rise_detect u_coin_rd (.clk(clk), .rst(rst), .d_i(moeda),    .ev_o(coin_ev));
   rise_detect u_conf_rd (.clk(clk), .rst(rst), .d_i(confirma), .ev_o(conf_ev));

   always_comb begin
      price    = PRICE_AGUA;
      op_valid = 1'b1;
      case (op)
         OP_AGUA:    price = PRICE_AGUA;
         OP_FANTA:   price = PRICE_FANTA;
         OP_GUARANA: price = PRICE_GUARANA;
         default:    op_valid = 1'b0;
      endcase
   end

   // Coins beyond the 4-bit range are dropped rather than wrapping to zero
   assign saldo_inc = (saldo_q == COIN_MAX) ? saldo_q : saldo_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      saldo_d   = saldo_q;
      troco_d   = '0;
      agua_d    = 1'b0;
      fanta_d   = 1'b0;
      guarana_d = 1'b0;
      devolve_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (conf_ev) begin
               // Transaction uses the pre-coin balance; a simultaneous coin starts the next one
               saldo_d = coin_ev ? 4'd1 : 4'd0;
               if (op_valid && saldo_q >= price) begin
                  state_d   = DISPENSE;
                  troco_d   = saldo_q - price;
                  agua_d    = (op == OP_AGUA);
                  fanta_d   = (op == OP_FANTA);
                  guarana_d = (op == OP_GUARANA);
               end else begin
                  state_d   = REFUND;
                  troco_d   = saldo_q;
                  devolve_d = 1'b1;
               end
            end else if (coin_ev) begin
`ifdef DRINK_OVERFLOW_REFUND_EN
               if (saldo_q == COIN_MAX) begin
                  state_d   = REFUND;
                  troco_d   = 4'd1;
                  devolve_d = 1'b1;
               end else begin
                  saldo_d = saldo_inc;
               end
`else
               saldo_d = saldo_inc;
`endif
            end
         end
         DISPENSE, REFUND: begin
            state_d = IDLE;
            if (coin_ev) saldo_d = saldo_inc;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         saldo_q   <= '0;
         troco_q   <= '0;
         agua_q    <= 1'b0;
         fanta_q   <= 1'b0;
         guarana_q <= 1'b0;
         devolve_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         saldo_q   <= saldo_d;
         troco_q   <= troco_d;
         agua_q    <= agua_d;
         fanta_q   <= fanta_d;
         guarana_q <= guarana_d;
         devolve_q <= devolve_d;
      end
   end

   assign entrega_agua    = agua_q;
   assign entrega_fanta   = fanta_q;
   assign entrega_guarana = guarana_q;
   assign sinal_devolve   = devolve_q;
   assign troco           = troco_q;
   assign saldo           = saldo_q;

endmodule

// File: tb/tb_drink.sv
// tb/tb_drink.sv - directed self-checking bench for the drink vending controller
module tb_drink;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       confirma = 1'b0;
   logic       moeda = 1'b0;
   logic [1:0] op = 2'b00;
   logic       entrega_agua, entrega_fanta, entrega_guarana, sinal_devolve;
   logic [3:0] troco, saldo;

   int n_checks = 0;
   int n_pass   = 0;

   drink dut (
      .clk(clk), .rst(rst), .confirma(confirma), .moeda(moeda), .op(op),
      .entrega_agua(entrega_agua), .entrega_fanta(entrega_fanta),
      .entrega_guarana(entrega_guarana), .sinal_devolve(sinal_devolve),
      .troco(troco), .saldo(saldo)
   );

   always #5 clk = ~clk;

   // pulses packed as {agua, fanta, guarana, devolve}
   function automatic logic [3:0] pulses();
      return {entrega_agua, entrega_fanta, entrega_guarana, sinal_devolve};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic coin();
      @(negedge clk); moeda = 1'b1;
      @(negedge clk); moeda = 1'b0;
   endtask

   task automatic coins(input int n);
      for (int i = 0; i < n; i++) coin();
   endtask

   task automatic buy(input string tag, input logic [1:0] o, input logic [3:0] exp_p,
                      input logic [3:0] exp_troco, input logic [3:0] exp_saldo);
      @(negedge clk); op = o; confirma = 1'b1;
      @(negedge clk);
      check({tag, "_pulse"}, {4'h0, pulses()}, {4'h0, exp_p});
      check({tag, "_troco"}, {4'h0, troco}, {4'h0, exp_troco});
      check({tag, "_saldo"}, {4'h0, saldo}, {4'h0, exp_saldo});
      confirma = 1'b0;
      @(negedge clk);
      check({tag, "_clear"}, {pulses(), troco}, 8'h00);
   endtask

   initial begin
      #20;
      @(negedge clk); rst = 1'b0;
      check("rst_saldo", {4'h0, saldo}, 8'h00);
      check("rst_troco", {4'h0, troco}, 8'h00);
      check("rst_pulse", {4'h0, pulses()}, 8'h00);

      op = 2'b00;
      coins(4);
      check("agua_bal", {4'h0, saldo}, 8'h04);
      buy("agua", 2'b00, 4'b1000, 4'd0, 4'd0);

      coins(3);
      buy("guar_short", 2'b10, 4'b0001, 4'd3, 4'd0);

      coins(7);
      buy("fanta", 2'b01, 4'b0100, 4'd1, 4'd0);

      coins(2);
      buy("invalid", 2'b11, 4'b0001, 4'd2, 4'd0);

      // simultaneous coin and confirm: pre-coin balance buys, coin is kept
      coins(4);
      @(negedge clk); op = 2'b00; confirma = 1'b1; moeda = 1'b1;
      @(negedge clk);
      check("sim_pulse", {4'h0, pulses()}, 8'h08);
      check("sim_troco", {4'h0, troco}, 8'h00);
      check("sim_saldo", {4'h0, saldo}, 8'h01);
      confirma = 1'b0; moeda = 1'b0;
      @(negedge clk);
      check("sim_clear", {pulses(), saldo}, 8'h01);
      buy("sim_drain", 2'b11, 4'b0001, 4'd1, 4'd0);

      // confirm held high with zero balance: one refund of zero, then nothing
      @(negedge clk); op = 2'b11; confirma = 1'b1;
      @(negedge clk);
      check("hold_pulse0", {pulses(), troco}, 8'h10);
      @(negedge clk);
      check("hold_pulse1", {pulses(), troco}, 8'h00);
      @(negedge clk);
      check("hold_pulse2", {pulses(), troco}, 8'h00);
      confirma = 1'b0;

      coins(15);
      check("sat_15", {4'h0, saldo}, 8'h0f);
      coin();
`ifdef DRINK_OVERFLOW_REFUND_EN
      check("sat_16_pulse", {pulses(), troco}, 8'h11);
`else
      check("sat_16_pulse", {pulses(), troco}, 8'h00);
`endif
      check("sat_16_saldo", {4'h0, saldo}, 8'h0f);

      // coin during the dispense cycle is credited after it
      @(negedge clk); op = 2'b01; confirma = 1'b1;
      @(negedge clk);
      check("f15_pulse", {pulses(), troco}, 8'h49);
      confirma = 1'b0; moeda = 1'b1;
      @(negedge clk);
      check("f15_coin", {pulses(), saldo}, 8'h01);
      moeda = 1'b0;
      buy("f15_drain", 2'b11, 4'b0001, 4'd1, 4'd0);

      // async reset in the middle of a dispense pulse
      coins(4);
      @(negedge clk); op = 2'b00; confirma = 1'b1;
      @(negedge clk);
      check("mid_pulse", {4'h0, pulses()}, 8'h08);
      #1 rst = 1'b1;
      #1;
      check("mid_rst", {pulses(), saldo}, 8'h00);
      check("mid_rst_troco", {4'h0, troco}, 8'h00);
      confirma = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("post_rst", {pulses(), saldo}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
